// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction fetch stage for the RV32I core.
//
// Owns the program counter and drives the byte address of a synchronous-read
// instruction ROM. The ROM registers rom_addr on every rising edge and returns
// the word one cycle later. Fetched {pc, inst} pairs are buffered in a 2-entry
// FIFO and delivered to decode over a valid/ready handshake. Execute may
// redirect the PC at any time: the FIFO and the returning response are flushed
// and the target is fetched in the same cycle.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   rom_addr             byte address to the ROM (ROM uses bits [13:2])
//   rom_data             ROM word for the address sampled at the previous edge
//   redirect_valid/_pc   PC change request from execute (pc[1:0] ignored)
//   out_valid/out_ready  handshake to decode
//   out_pc/out_inst      FIFO head: instruction and its byte address
//   perf_stall_cycles    cycles with out_valid && !out_ready (optional)
//
// Optional feature: define RV32I_FETCH_PERF_EN to add perf_stall_cycles.

module rv32i_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
`ifdef RV32I_FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles
`endif
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   logic [31:0]        pc_q, pc_d;
   logic               infl_q, infl_d;
   logic [31:0]        infl_pc_q, infl_pc_d;
   fetch_entry_t [1:0] fifo_q, fifo_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [1:0]         count_q, count_d;

   logic               pop;
   logic               push;
   logic               issue;
   logic               wr_ptr;
   logic [2:0]         occ;

   logic               unused_bits;
   assign unused_bits = ^redirect_pc[1:0];

   // Address path is combinational so a redirect fetches its target in the
   // same cycle; reset pins the ROM to RESET_PC.
   always_comb begin
      rom_addr = pc_q;
      if (rst)
         rom_addr = RESET_PC;
      else if (redirect_valid)
         rom_addr = {redirect_pc[31:2], 2'b00};
   end

   assign out_valid = (count_q != 2'd0);
   assign out_pc    = fifo_q[rd_ptr_q].pc;
   assign out_inst  = fifo_q[rd_ptr_q].inst;

   always_comb begin
      pc_d      = pc_q;
      infl_d    = 1'b0;
      infl_pc_d = infl_pc_q;
      fifo_d    = fifo_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      pop    = out_valid && out_ready;
      // A redirect kills the response returning this cycle.
      push   = infl_q && !redirect_valid;
      wr_ptr = rd_ptr_q ^ count_q[0];
      // Only issue when the FIFO is guaranteed to have room for the
      // response next cycle, counting the one already in flight.
      occ    = {1'b0, count_q} + {2'b00, infl_q};
      issue  = redirect_valid || (occ <= (3'd1 + {2'b00, pop}));

      if (issue) begin
         infl_d    = 1'b1;
         infl_pc_d = rom_addr;
         pc_d      = rom_addr + 32'd4;
      end

      if (redirect_valid) begin
         // Any pop this cycle already delivered its entry; drop the rest.
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr].pc   = infl_pc_q;
            fifo_d[wr_ptr].inst = rom_data;
         end
         if (pop)
            rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         infl_q    <= 1'b0;
         infl_pc_q <= 32'd0;
         fifo_q    <= '0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         pc_q      <= pc_d;
         infl_q    <= infl_d;
         infl_pc_q <= infl_pc_d;
         fifo_q    <= fifo_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // The issue rule keeps a slot free for every response.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && count_q == 2'd2));

`ifdef RV32I_FETCH_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (out_valid && !out_ready)
         perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         perf_q <= 32'd0;
      else
         perf_q <= perf_d;
   end

   assign perf_stall_cycles = perf_q;
`endif

endmodule
